imm_extend_pipe: RTL

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 134 +++++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// Immediate extension stage with a 2-entry in-order output buffer.
// The extension is computed when an immediate is accepted and stored together
// with its mode, so buffered results never change until they are popped.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | no result buffered, out_valid=0
// ST_ONE   | one result in the head slot
// ST_FULL  | head and tail slots both hold results, in_ready=0
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  localparam int PAD = OUT_W - IN_W;

  localparam logic [1:0] MODE_ZERO   = 2'd0;
  localparam logic [1:0] MODE_SIGN   = 2'd1;
  localparam logic [1:0] MODE_UPPER  = 2'd2;
  localparam logic [1:0] MODE_BRANCH = 2'd3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   head_data_q, head_data_d;
  logic [1:0]         head_mode_q, head_mode_d;
  logic [OUT_W-1:0]   tail_data_q, tail_data_d;
  logic [1:0]         tail_mode_q, tail_mode_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [OUT_W-1:0]   sign_ext;
  logic [OUT_W-1:0]   ext_data;
  logic               push;
  logic               pop;

  // Extend the incoming immediate according to its mode.
  always_comb begin
    sign_ext = {{PAD{in_imm[IN_W-1]}}, in_imm};
    ext_data = '0;
    unique case (in_mode)
      MODE_ZERO:   ext_data = {{PAD{1'b0}}, in_imm};
      MODE_SIGN:   ext_data = sign_ext;
      MODE_UPPER:  ext_data = {in_imm, {PAD{1'b0}}};
      MODE_BRANCH: ext_data = {sign_ext[OUT_W-3:0], 2'b00};
      default:     ext_data = '0;
    endcase
  end

  // Buffer occupancy and slot updates; handshake flags are registered from
  // the next state so in_ready never depends combinationally on out_ready.
  always_comb begin
    push        = in_valid & in_ready_q;
    pop         = out_valid_q & out_ready;
    state_d     = state_q;
    head_data_d = head_data_q;
    head_mode_d = head_mode_q;
    tail_data_d = tail_data_q;
    tail_mode_d = tail_mode_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_data_d = ext_data;
          head_mode_d = in_mode;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_data_d = ext_data;
          head_mode_d = in_mode;
        end else if (push) begin
          tail_data_d = ext_data;
          tail_mode_d = in_mode;
          state_d     = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_mode_d = tail_mode_q;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      head_data_q <= '0;
      head_mode_q <= '0;
      tail_data_q <= '0;
      tail_mode_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_mode_q <= head_mode_d;
      tail_data_q <= tail_data_d;
      tail_mode_q <= tail_mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_data_q;
  assign out_mode  = head_mode_q;

endmodule
